huffman_enc_ctrl: RTL and testbench

Sequencer between the Huffman AXI-Lite register slave and the Huffman encoder core. Register writes load a job (symbol count, start or abort). The block gates symbols from the DATA_IN path into the encoder and packs the variable-length codes MSB-first into 32-bit words for the DATA_OUT path. It reports busy, done and error status back to the register map.

---
 rtl/huffman_enc_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_huffman_enc_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/huffman_enc_ctrl.sv
// Job sequencer and MSB-first bit packer between the Huffman register slave and encoder core.
// Optional irq output is enabled with `define HUFF_ENC_CTRL_IRQ_EN.
module huffman_enc_ctrl #(
    parameter int SYM_W  = 8,
    parameter int CODE_W = 16,
    parameter int CNT_W  = 16,
    localparam int LEN_W = $clog2(CODE_W + 1)
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic              ctrl_wr,
    input  logic [31:0]       ctrl_wdata,
    input  logic              sym_in_valid,
    input  logic [SYM_W-1:0]  sym_in_data,
    output logic              sym_in_ready,
    output logic              enc_sym_valid,
    output logic [SYM_W-1:0]  enc_sym_data,
    input  logic              enc_sym_ready,
    input  logic              enc_code_valid,
    input  logic [CODE_W-1:0] enc_code,
    input  logic [LEN_W-1:0]  enc_code_len,
    output logic              enc_code_ready,
    output logic              out_valid,
    output logic [31:0]       out_word,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  words_out
`ifdef HUFF_ENC_CTRL_IRQ_EN
    ,
    output logic              irq
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t             state, state_nx;
    logic [63:0]        acc, acc_nx;
    logic [6:0]         fill, fill_nx;
    logic [CNT_W-1:0]   sym_left, sym_left_nx;
    logic [CNT_W-1:0]   code_left, code_left_nx;
    logic [CNT_W-1:0]   words_nx;
    logic               err_nx;

    logic               start, abort;
    logic [CNT_W-1:0]   job_cnt;
    logic               run, out_fire, code_fire, len_ok;
    logic [CODE_W-1:0]  code_mask;
    logic [63:0]        code_ext;
    logic [6:0]         shamt;

    assign start   = ctrl_wr & ctrl_wdata[0];
    assign abort   = ctrl_wr & ctrl_wdata[1];
    assign job_cnt = ctrl_wdata[8+CNT_W-1:8];

    assign run  = (state == RUN);
    assign busy = run | (state == FLUSH);
    assign done = (state == DONE);

    assign enc_sym_valid = run & sym_in_valid & (sym_left != '0);
    assign sym_in_ready  = run & enc_sym_ready & (sym_left != '0);
    assign enc_sym_data  = run ? sym_in_data : '0;

    assign enc_code_ready = run & (code_left != '0) & (fill <= 7'd32);
    assign code_fire      = enc_code_valid & enc_code_ready;
    assign len_ok         = (enc_code_len != '0) && (enc_code_len <= LEN_W'(CODE_W));
    assign code_mask      = ~({CODE_W{1'b1}} << enc_code_len);
    assign code_ext       = {{(64-CODE_W){1'b0}}, enc_code & code_mask};

    // In FLUSH a partial word is offered only after all full words are gone
    assign out_valid = (busy & (fill >= 7'd32)) | ((state == FLUSH) & (fill != '0));
    assign out_word  = acc[63:32];
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        state_nx     = state;
        acc_nx       = acc;
        fill_nx      = fill;
        sym_left_nx  = sym_left;
        code_left_nx = code_left;
        words_nx     = words_out;
        err_nx       = err;
        shamt        = '0;

        if (out_fire) begin
            if (fill >= 7'd32) begin
                acc_nx  = {acc[31:0], 32'd0};
                fill_nx = fill - 7'd32;
            end else begin
                acc_nx  = '0;
                fill_nx = '0;
            end
            words_nx = words_out + CNT_W'(1);
        end

        // Append goes after the emit shift so a same-cycle accept lands at fill-32
        if (code_fire) begin
            code_left_nx = code_left - CNT_W'(1);
            if (len_ok) begin
                shamt   = 7'd64 - fill_nx - 7'(enc_code_len);
                acc_nx  = acc_nx | (code_ext << shamt);
                fill_nx = fill_nx + 7'(enc_code_len);
            end else begin
                err_nx = 1'b1;
            end
        end

        if (enc_sym_valid && enc_sym_ready)
            sym_left_nx = sym_left - CNT_W'(1);

        case (state)
            RUN:     if (code_left == '0) state_nx = FLUSH;
            FLUSH:   if (fill == '0) state_nx = DONE;
            default: ;
        endcase

        if (start) begin
            if (job_cnt == '0) begin
                err_nx = 1'b1;
            end else if (state == IDLE || state == DONE) begin
                state_nx     = RUN;
                sym_left_nx  = job_cnt;
                code_left_nx = job_cnt;
                words_nx     = '0;
                err_nx       = 1'b0;
                acc_nx       = '0;
                fill_nx      = '0;
            end else begin
                err_nx = 1'b1;
            end
        end

        if (abort) begin
            state_nx     = IDLE;
            acc_nx       = '0;
            fill_nx      = '0;
            sym_left_nx  = '0;
            code_left_nx = '0;
            words_nx     = '0;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state     <= IDLE;
            acc       <= '0;
            fill      <= '0;
            sym_left  <= '0;
            code_left <= '0;
            words_out <= '0;
            err       <= 1'b0;
        end else begin
            state     <= state_nx;
            acc       <= acc_nx;
            fill      <= fill_nx;
            sym_left  <= sym_left_nx;
            code_left <= code_left_nx;
            words_out <= words_nx;
            err       <= err_nx;
        end
    end

`ifdef HUFF_ENC_CTRL_IRQ_EN
    logic irq_set;
    assign irq_set = ((state_nx == DONE) && (state != DONE)) || (err_nx && !err);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN)
            irq <= 1'b0;
        else if (irq_set)
            irq <= 1'b1;
        else if (ctrl_wr && ctrl_wdata[2])
            irq <= 1'b0;
    end

    logic unused_bits;
    assign unused_bits = ^{ctrl_wdata[31:8+CNT_W], ctrl_wdata[7:3]};
`else
    logic unused_bits;
    assign unused_bits = ^{ctrl_wdata[31:8+CNT_W], ctrl_wdata[7:2]};
`endif

endmodule

// File: tb/tb_huffman_enc_ctrl.sv
// Directed bench for huffman_enc_ctrl: code feeder, output-word scoreboard, immediate-assert checks.
module tb_huffman_enc_ctrl;

    typedef struct packed {
        logic [4:0]  len;
        logic [15:0] code;
    } code_t;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic        ctrl_wr;
    logic [31:0] ctrl_wdata;
    logic        sym_in_valid;
    logic [7:0]  sym_in_data;
    logic        sym_in_ready;
    logic        enc_sym_valid;
    logic [7:0]  enc_sym_data;
    logic        enc_sym_ready;
    logic        enc_code_valid;
    logic [15:0] enc_code;
    logic [4:0]  enc_code_len;
    logic        enc_code_ready;
    logic        out_valid;
    logic [31:0] out_word;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] words_out;
`ifdef HUFF_ENC_CTRL_IRQ_EN
    logic        irq;
`endif

    int n_pass = 0;
    int n_tot  = 0;
    int n_fail = 0;
    int sym_cnt = 0;
    code_t       code_q[$];
    logic [31:0] exp_q[$];

    always #5 ACLK = ~ACLK;

    huffman_enc_ctrl dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .ctrl_wr(ctrl_wr), .ctrl_wdata(ctrl_wdata),
        .sym_in_valid(sym_in_valid), .sym_in_data(sym_in_data), .sym_in_ready(sym_in_ready),
        .enc_sym_valid(enc_sym_valid), .enc_sym_data(enc_sym_data), .enc_sym_ready(enc_sym_ready),
        .enc_code_valid(enc_code_valid), .enc_code(enc_code), .enc_code_len(enc_code_len),
        .enc_code_ready(enc_code_ready),
        .out_valid(out_valid), .out_word(out_word), .out_ready(out_ready),
        .busy(busy), .done(done), .err(err), .words_out(words_out)
`ifdef HUFF_ENC_CTRL_IRQ_EN
        , .irq(irq)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    function automatic logic [31:0] mk(input bit st, input bit ab, input logic [15:0] cnt);
        return {8'h00, cnt, 6'd0, ab, st};
    endfunction

    task automatic write_ctrl(input logic [31:0] w);
        step();
        ctrl_wr    = 1'b1;
        ctrl_wdata = w;
        step();
        ctrl_wr    = 1'b0;
        ctrl_wdata = '0;
    endtask

    task automatic wait_done(input int bound, input string tag);
        for (int i = 0; i < bound; i++) begin
            @(negedge ACLK);
            if (done) break;
        end
        chk(tag, 32'(done), 32'd1);
    endtask

    task automatic push_code(input logic [4:0] len, input logic [15:0] code);
        code_t c;
        c.len  = len;
        c.code = code;
        code_q.push_back(c);
    endtask

    // Encoder model: presents queued codes, pops one per accepted handshake
    initial begin : feeder
        bit took;
        enc_code_valid = 1'b0;
        enc_code       = '0;
        enc_code_len   = '0;
        forever begin
            @(negedge ACLK);
            took = enc_code_valid && enc_code_ready;
            @(posedge ACLK);
            #1;
            if (took && code_q.size() > 0) void'(code_q.pop_front());
            if (code_q.size() > 0) begin
                enc_code_valid = 1'b1;
                enc_code       = code_q[0].code;
                enc_code_len   = code_q[0].len;
            end else begin
                enc_code_valid = 1'b0;
            end
        end
    end

    always @(negedge ACLK) begin
        if (enc_sym_valid && enc_sym_ready) sym_cnt++;
        if (out_valid && out_ready) begin
            n_tot++;
            assert (exp_q.size() > 0) n_pass++;
            else begin
                n_fail++;
                $error("FAIL word_unexpected observed=%h expected=none", out_word);
            end
            if (exp_q.size() > 0) chk("word", out_word, exp_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ARESETN       = 1'b0;
        ctrl_wr       = 1'b0;
        ctrl_wdata    = '0;
        sym_in_valid  = 1'b1;
        sym_in_data   = 8'h5A;
        enc_sym_ready = 1'b1;
        out_ready     = 1'b1;
        repeat (2) @(posedge ACLK);
        #1;
        chk("rst_flags", {26'd0, busy, done, err, out_valid, enc_code_ready, sym_in_ready}, 32'd0);
        chk("rst_word", out_word, 32'd0);
        ARESETN = 1'b1;

        // Job 1: four 8-bit codes make one full word
        sym_cnt = 0;
        push_code(5'd8, 16'h00A1); push_code(5'd8, 16'h00B2);
        push_code(5'd8, 16'h00C3); push_code(5'd8, 16'h00D4);
        exp_q.push_back(32'hA1B2C3D4);
        write_ctrl(mk(1, 0, 16'd4));
        @(negedge ACLK);
        chk("j1_busy", 32'(busy), 32'd1);
        chk("j1_sym_pass", {23'd0, enc_sym_valid, enc_sym_data}, {23'd0, 1'b1, 8'h5A});
        wait_done(40, "j1_done");
        chk("j1_words", 32'(words_out), 32'd1);
        chk("j1_err_busy", {30'd0, err, busy}, 32'd0);
        chk("j1_syms", sym_cnt, 32'd4);
        chk("j1_q", exp_q.size(), 32'd0);
`ifdef HUFF_ENC_CTRL_IRQ_EN
        chk("j1_irq", 32'(irq), 32'd1);
`endif

        // Job 2: 15 bits total, flushed with zero padding; upper code bits must be masked
        push_code(5'd5, 16'hFFF5); push_code(5'd5, 16'h0015); push_code(5'd5, 16'h0015);
        exp_q.push_back(32'hAD6A0000);
        write_ctrl(mk(1, 0, 16'd3));
        wait_done(40, "j2_done");
        chk("j2_words", 32'(words_out), 32'd1);
        chk("j2_q", exp_q.size(), 32'd0);

        // Job 3: output stall backs up the packer
        sym_cnt   = 0;
        out_ready = 1'b0;
        push_code(5'd16, 16'h1111); push_code(5'd16, 16'h2222); push_code(5'd16, 16'h3333);
        push_code(5'd16, 16'h4444); push_code(5'd16, 16'h5555); push_code(5'd16, 16'h6666);
        exp_q.push_back(32'h11112222); exp_q.push_back(32'h33334444); exp_q.push_back(32'h55556666);
        write_ctrl(mk(1, 0, 16'd6));
        repeat (10) @(negedge ACLK);
        chk("j3_stall_rdy", {30'd0, enc_code_valid, enc_code_ready}, 32'd2);
        chk("j3_stall_left", code_q.size(), 32'd3);
        chk("j3_stall_word", out_word, 32'h11112222);
        chk("j3_stall_vld", 32'(out_valid), 32'd1);
        repeat (9) @(negedge ACLK);
        chk("j3_hold_word", out_word, 32'h11112222);
        step();
        out_ready = 1'b1;
        wait_done(40, "j3_done");
        chk("j3_words", 32'(words_out), 32'd3);
        chk("j3_syms", sym_cnt, 32'd6);
        chk("j3_q", exp_q.size(), 32'd0);

        // Job 4: abort mid-run, then a fresh one-code job
        sym_cnt   = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) push_code(5'd8, 16'h0077);
        write_ctrl(mk(1, 0, 16'd8));
        for (int i = 0; i < 40; i++) begin
            @(negedge ACLK);
            if (sym_cnt >= 3) break;
        end
        chk("j4_sym3", 32'(sym_cnt >= 3), 32'd1);
        write_ctrl(mk(0, 1, 16'd0));
        @(negedge ACLK);
        chk("j4_abort_flags", {27'd0, busy, done, err, out_valid, enc_code_ready}, 32'd0);
        chk("j4_abort_word", out_word, 32'd0);
        code_q.delete();
        out_ready = 1'b1;
        step(); step();
        push_code(5'd8, 16'h00FF);
        exp_q.push_back(32'hFF000000);
        write_ctrl(mk(1, 0, 16'd1));
        wait_done(40, "j4_done");
        chk("j4_words", 32'(words_out), 32'd1);
        chk("j4_q", exp_q.size(), 32'd0);

        // Job 5: start with count 0, then start during RUN
        write_ctrl(mk(1, 0, 16'd0));
        @(negedge ACLK);
        chk("j5_cnt0", {30'd0, err, done}, 32'd3);
        push_code(5'd8, 16'h0011); push_code(5'd8, 16'h0022);
        push_code(5'd8, 16'h0033); push_code(5'd8, 16'h0044);
        exp_q.push_back(32'h11223344);
        write_ctrl(mk(1, 0, 16'd4));
        @(negedge ACLK);
        chk("j5_clr", {30'd0, err, busy}, 32'd1);
        write_ctrl(mk(1, 0, 16'd5));
        @(negedge ACLK);
        chk("j5_restart", {30'd0, err, busy}, 32'd3);
        wait_done(40, "j5_done");
        chk("j5_words", 32'(words_out), 32'd1);
        chk("j5_q", exp_q.size(), 32'd0);

        // Job 6: zero and oversize lengths are dropped but still consume a slot
        push_code(5'd0, 16'h00AB); push_code(5'd17, 16'h1234); push_code(5'd8, 16'h00C3);
        exp_q.push_back(32'hC3000000);
        write_ctrl(mk(1, 0, 16'd3));
        @(negedge ACLK);
        chk("j6_err0", 32'(err), 32'd0);
        wait_done(40, "j6_done");
        chk("j6_err1", 32'(err), 32'd1);
        chk("j6_words", 32'(words_out), 32'd1);
        chk("j6_q", exp_q.size(), 32'd0);

        // Job 7: async reset while a partial word is pending in FLUSH
        out_ready = 1'b0;
        push_code(5'd16, 16'hAAAA);
        write_ctrl(mk(1, 0, 16'd1));
        repeat (6) @(negedge ACLK);
        chk("j7_flush", {29'd0, busy, out_valid, done}, 32'd6);
        chk("j7_flush_word", out_word, 32'hAAAA0000);
        @(posedge ACLK);
        #3;
        ARESETN = 1'b0;
        #1;
        chk("j7_rst_flags", {25'd0, busy, done, err, out_valid, enc_code_ready, sym_in_ready, enc_sym_valid}, 32'd0);
        chk("j7_rst_data", {out_word[23:0], enc_sym_data}, 32'd0);
        chk("j7_rst_words", {16'd0, words_out}, 32'd0);
        code_q.delete();
        repeat (2) @(posedge ACLK);
        #1;
        ARESETN   = 1'b1;
        out_ready = 1'b1;
        step();
        @(negedge ACLK);
        chk("j7_idle", {29'd0, busy, done, out_valid}, 32'd0);
        chk("j7_q", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
